// File: rtl/mul_div_unit_pkg.sv
// Shared constants for the iterative RV32M multiply/divide unit:
// operand width, mulDiv_op encodings and FSM states.
package mul_div_unit_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 5;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIVU   = 3'b100;
  localparam logic [2:0] MD_DIV    = 3'b101;
  localparam logic [2:0] MD_REMU   = 3'b110;
  localparam logic [2:0] MD_REM    = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} md_state_e;

endpackage

// File: rtl/mul_div_sign_fix.sv
// Result conditioning: optional two's-complement negate of the 64-bit product
// or of the quotient/remainder word, then select the architectural result.
module mul_div_sign_fix
  import mul_div_unit_pkg::*;
(
  input  logic [2:0]      op_i,
  input  logic            neg_i,
  input  logic [XLEN-1:0] hi_i,
  input  logic [XLEN-1:0] lo_i,
  output logic [XLEN-1:0] res_o
);

  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   word, word_fix;

  assign prod     = {hi_i, lo_i};
  assign prod_fix = neg_i ? -prod : prod;

  // Divide: hi holds the remainder, lo the quotient; op[1] marks rem/remu.
  assign word     = op_i[1] ? hi_i : lo_i;
  assign word_fix = neg_i ? -word : word;

  always_comb begin
    res_o = word_fix;
    if (!op_i[2]) begin
      if (op_i == MD_MUL) res_o = prod_fix[XLEN-1:0];
      else                res_o = prod_fix[2*XLEN-1:XLEN];
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply and restoring
// divide sharing one XLEN+1 adder, one operation in flight, kill aborts.
module mul_div_unit
  import mul_div_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [4:0]      rd_i,
  input  logic            kill_i,
  output logic            ready_o,
  output logic            result_valid_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o
);

  md_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       op_q;
  logic [4:0]       rd_q;
  logic             neg_res;
  logic [XLEN-1:0]  acc, lo, opb;

  logic            is_mul_i, a_sgn, b_sgn, a_neg, b_neg, neg_res_d;
  logic            div_zero, div_ovf, special, q0;
  logic [XLEN-1:0] a_mag, b_mag, spec_res;

  assign is_mul_i = ~op_i[2];
  assign a_sgn = (op_i == MD_MUL) || (op_i == MD_MULH) || (op_i == MD_MULHSU) ||
                 (op_i == MD_DIV) || (op_i == MD_REM);
  assign b_sgn = (op_i == MD_MUL) || (op_i == MD_MULH) ||
                 (op_i == MD_DIV) || (op_i == MD_REM);
  assign a_neg = a_sgn & a_i[XLEN-1];
  assign b_neg = b_sgn & b_i[XLEN-1];
  assign a_mag = a_neg ? -a_i : a_i;
  assign b_mag = b_neg ? -b_i : b_i;
  // Remainder takes the dividend's sign; everything else the XOR of both.
  assign neg_res_d = (op_i[2] & op_i[1]) ? a_neg : (a_neg ^ b_neg);

  assign div_zero = ~is_mul_i & (b_i == '0);
  assign div_ovf  = ((op_i == MD_DIV) || (op_i == MD_REM)) &&
                    (a_i == {1'b1, {(XLEN-1){1'b0}}}) && (b_i == '1);
  assign special  = div_zero | div_ovf;

  always_comb begin
    spec_res = '0;
    if (div_zero) spec_res = op_i[1] ? a_i : '1;
    else          spec_res = op_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  // The first iteration is folded into the accept edge (its add degenerates to
  // a mux / compare-with-one), so CALC holds counter 1..31 and DONE lands on cycle 33.
  assign q0 = a_mag[XLEN-1] & (b_mag == {{(XLEN-1){1'b0}}, 1'b1});

  logic            mul_q;
  logic [XLEN:0]   add_a, add_b, sum;

  assign mul_q = ~op_q[2];
  assign add_a = mul_q ? {1'b0, acc} : {acc, lo[XLEN-1]};
  assign add_b = mul_q ? (lo[0] ? {1'b0, opb} : '0) : ~{1'b0, opb};
  assign sum   = add_a + add_b + {{XLEN{1'b0}}, ~mul_q};

  logic [XLEN-1:0] fix_res;

  mul_div_sign_fix u_fix (
    .op_i  (op_q),
    .neg_i (neg_res),
    .hi_i  (acc),
    .lo_i  (lo),
    .res_o (fix_res)
  );

  assign ready_o = (state == S_IDLE) || (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      cnt            <= '0;
      op_q           <= '0;
      rd_q           <= '0;
      neg_res        <= 1'b0;
      acc            <= '0;
      lo             <= '0;
      opb            <= '0;
      result_valid_o <= 1'b0;
      result_o       <= '0;
      rd_o           <= '0;
    end else begin
      result_valid_o <= 1'b0;
      if (kill_i) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            state <= S_IDLE;
            if (start_i) begin
              op_q    <= op_i;
              rd_q    <= rd_i;
              neg_res <= neg_res_d;
              opb     <= b_mag;
              if (special) begin
                result_o       <= spec_res;
                rd_o           <= rd_i;
                result_valid_o <= 1'b1;
                state          <= S_DONE;
              end else begin
                state <= S_CALC;
                cnt   <= {{(CNT_W-1){1'b0}}, 1'b1};
                if (is_mul_i) begin
                  acc <= a_mag[0] ? {1'b0, b_mag[XLEN-1:1]} : '0;
                  lo  <= {a_mag[0] & b_mag[0], a_mag[XLEN-1:1]};
                end else begin
                  acc <= {{(XLEN-1){1'b0}}, a_mag[XLEN-1] & ~q0};
                  lo  <= {a_mag[XLEN-2:0], q0};
                end
              end
            end
          end
          S_CALC: begin
            cnt <= cnt + 1'b1;
            if (cnt == '1) state <= S_FIX;
            if (mul_q) begin
              acc <= sum[XLEN:1];
              lo  <= {sum[0], lo[XLEN-1:1]};
            end else if (sum[XLEN]) begin
              acc <= add_a[XLEN-1:0];
              lo  <= {lo[XLEN-2:0], 1'b0};
            end else begin
              acc <= sum[XLEN-1:0];
              lo  <= {lo[XLEN-2:0], 1'b1};
            end
          end
          S_FIX: begin
            result_o       <= fix_res;
            rd_o           <= rd_q;
            result_valid_o <= 1'b1;
            state          <= S_DONE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: latency, results, specials, kill, reset.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start_i, kill_i;
  logic [2:0]  op_i;
  logic [31:0] a_i, b_i;
  logic [4:0]  rd_i;
  logic        ready_o, result_valid_o;
  logic [31:0] result_o;
  logic [4:0]  rd_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mul_div_unit dut (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start_i),
    .op_i           (op_i),
    .a_i            (a_i),
    .b_i            (b_i),
    .rd_i           (rd_i),
    .kill_i         (kill_i),
    .ready_o        (ready_o),
    .result_valid_o (result_valid_o),
    .result_o       (result_o),
    .rd_o           (rd_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    op_i = op; a_i = a; b_i = b; rd_i = rd; start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  // Caller is at cycle lat0 relative to the accept edge.
  task automatic wait_res(input string tag, input int lat0, input int exp_lat,
                          input logic [31:0] exp_res, input logic [4:0] exp_rd);
    int   lat;
    logic busy_rdy;
    lat = lat0;
    busy_rdy = 1'b0;
    while (!result_valid_o && lat < 80) begin
      busy_rdy |= ready_o;
      step();
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " result"}, result_o, exp_res);
    chk({tag, " rd"}, {27'b0, rd_o}, {27'b0, exp_rd});
    chk({tag, " ready while busy"}, {31'b0, busy_rdy}, 32'd0);
    chk({tag, " ready in done"}, {31'b0, ready_o}, 32'd1);
  endtask

  initial begin
    logic sawv;
    rst = 1'b1; start_i = 1'b0; kill_i = 1'b0;
    op_i = '0; a_i = '0; b_i = '0; rd_i = '0;
    step(); step();
    chk("reset ready", {31'b0, ready_o}, 32'd1);
    chk("reset valid", {31'b0, result_valid_o}, 32'd0);
    chk("reset result", result_o, 32'd0);
    chk("reset rd", {27'b0, rd_o}, 32'd0);
    rst = 1'b0;
    step();

    issue(MD_MUL, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5);
    wait_res("mul", 1, 33, 32'hFFFF_FFEB, 5'd5);
    // issued in the DONE cycle of the previous op
    issue(MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12);
    wait_res("mulhu b2b", 1, 33, 32'hFFFF_FFFE, 5'd12);
    step();
    chk("valid single pulse", {31'b0, result_valid_o}, 32'd0);

    issue(MD_MULH, 32'h8000_0000, 32'h8000_0000, 5'd6);
    wait_res("mulh", 1, 33, 32'h4000_0000, 5'd6);
    step();
    issue(MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7);
    wait_res("mulhsu", 1, 33, 32'hFFFF_FFFF, 5'd7);
    step();

    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2, 5'd8);
    wait_res("div", 1, 33, 32'hFFFF_FFFD, 5'd8);
    step();
    issue(MD_REM, 32'hFFFF_FFF9, 32'd2, 5'd9);
    wait_res("rem", 1, 33, 32'hFFFF_FFFF, 5'd9);
    step();
    issue(MD_DIVU, 32'hFFFF_FFF9, 32'd2, 5'd10);
    wait_res("divu", 1, 33, 32'h7FFF_FFFC, 5'd10);
    step();
    issue(MD_REMU, 32'hFFFF_FFF9, 32'd2, 5'd11);
    wait_res("remu", 1, 33, 32'h0000_0001, 5'd11);
    step();

    issue(MD_DIV, 32'd5, 32'd0, 5'd1);
    wait_res("div by zero", 1, 1, 32'hFFFF_FFFF, 5'd1);
    step();
    issue(MD_REMU, 32'd5, 32'd0, 5'd2);
    wait_res("remu by zero", 1, 1, 32'd5, 5'd2);
    step();
    issue(MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4);
    wait_res("rem overflow", 1, 1, 32'd0, 5'd4);
    step();
    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3);
    wait_res("div overflow", 1, 1, 32'h8000_0000, 5'd3);
    step();

    // kill in cycle 10, re-issue in cycle 11
    issue(MD_DIV, 32'd100, 32'd7, 5'd8);
    sawv = 1'b0;
    for (int c = 1; c < 10; c++) begin
      sawv |= result_valid_o;
      step();
    end
    kill_i = 1'b1;
    sawv |= result_valid_o;
    step();
    kill_i = 1'b0;
    sawv |= result_valid_o;
    chk("kill ready", {31'b0, ready_o}, 32'd1);
    chk("kill no valid", {31'b0, sawv}, 32'd0);
    chk("kill result held", result_o, 32'h8000_0000);
    chk("kill rd held", {27'b0, rd_o}, 32'd3);
    issue(MD_MUL, 32'd3, 32'd4, 5'd9);
    wait_res("mul after kill", 1, 33, 32'd12, 5'd9);
    step();

    // kill and start together: a div-by-zero would return at once if accepted
    op_i = MD_DIV; a_i = 32'd5; b_i = 32'd0; rd_i = 5'd10;
    start_i = 1'b1; kill_i = 1'b1;
    step();
    start_i = 1'b0; kill_i = 1'b0;
    chk("kill+start no valid", {31'b0, result_valid_o}, 32'd0);
    chk("kill+start rd held", {27'b0, rd_o}, 32'd9);
    chk("kill+start ready", {31'b0, ready_o}, 32'd1);

    // start pulsed in cycle 5 of a busy divu is ignored
    issue(MD_DIVU, 32'd100, 32'd7, 5'd11);
    for (int c = 1; c < 5; c++) step();
    op_i = MD_DIV; a_i = 32'd5; b_i = 32'd0; rd_i = 5'd13; start_i = 1'b1;
    step();
    start_i = 1'b0;
    wait_res("divu busy start", 6, 33, 32'd14, 5'd11);
    step();

    // reset in cycle 20 of a div
    issue(MD_DIV, 32'd1000, 32'd3, 5'd14);
    for (int c = 1; c < 20; c++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid reset valid", {31'b0, result_valid_o}, 32'd0);
    chk("mid reset result", result_o, 32'd0);
    chk("mid reset rd", {27'b0, rd_o}, 32'd0);
    chk("mid reset ready", {31'b0, ready_o}, 32'd1);
    sawv = 1'b0;
    for (int c = 0; c < 40; c++) begin
      step();
      sawv |= result_valid_o;
    end
    chk("mid reset no valid", {31'b0, sawv}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
